// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and register-branch stalls, branch flush, halt drain.
// Optional stall counter output enabled by defining HAZ_PERF_CNT_EN.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_src1,
  input  logic [3:0] id_src2,
  input  logic       id_use1,
  input  logic       id_use2,
  input  logic       id_br_reg,
  input  logic       id_halt,
  input  logic [3:0] ex_dst,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [3:0] mem_dst,
  input  logic       mem_regwrite,
  input  logic       branch_taken,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       halted
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0] state;
  logic [1:0] nextState;
  logic [1:0] effState;
  logic [1:0] drainCnt;
  logic [1:0] nextDrainCnt;
  logic       loadUse;
  logic       brHazard;
  logic       hazard;

  // Register-branch operands are read in decode, so any in-flight writer of src1 must stall it.
  assign loadUse  = id_valid && ex_regwrite && ex_memread && (ex_dst != 4'd0) &&
                    ((id_use1 && (ex_dst == id_src1)) || (id_use2 && (ex_dst == id_src2)));
  assign brHazard = id_valid && id_br_reg && (id_src1 != 4'd0) &&
                    ((ex_regwrite && (ex_dst == id_src1)) || (mem_regwrite && (mem_dst == id_src1)));
  assign hazard   = loadUse || brHazard;

  // Outputs behave as in RUN while reset is held so the front end keeps fetching.
  assign effState = rst ? RUN : state;

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    nextState    = state;
    nextDrainCnt = drainCnt;
    case (effState)
      RUN: begin
        if (hazard) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
        end else if (id_valid && id_halt) begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          nextState    = DRAIN;
          nextDrainCnt = 2'd3;
        end else if (branch_taken) begin
          ifid_flush = 1'b1;
        end
      end
      DRAIN: begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        idex_bubble  = 1'b1;
        nextDrainCnt = drainCnt - 2'd1;
        if (drainCnt == 2'd1) begin
          nextState = HALTED;
        end
      end
      HALTED: begin
        pc_we       = 1'b0;
        ifid_we     = 1'b0;
        idex_bubble = 1'b1;
      end
      default: begin
        nextState = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      drainCnt <= 2'd0;
      halted   <= 1'b0;
    end else begin
      state    <= nextState;
      drainCnt <= nextDrainCnt;
      halted   <= (nextState == HALTED);
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Counts only RUN-state hazard stalls; drain and halt bubbles are not stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
    end else if ((state == RUN) && hazard && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs, a monitor pops and compares.
module tb_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       idValid;
  logic [3:0] idSrc1;
  logic [3:0] idSrc2;
  logic       idUse1;
  logic       idUse2;
  logic       idBrReg;
  logic       idHalt;
  logic [3:0] exDst;
  logic       exRegwrite;
  logic       exMemread;
  logic [3:0] memDst;
  logic       memRegwrite;
  logic       branchTaken;
  logic       pcWe;
  logic       ifidWe;
  logic       ifidFlush;
  logic       idexBubble;
  logic       halted;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stallCnt;
`endif

  typedef struct packed {
    logic       valid;
    logic [3:0] src1;
    logic [3:0] src2;
    logic       use1;
    logic       use2;
    logic       brReg;
    logic       halt;
    logic [3:0] exDst;
    logic       exRw;
    logic       exMr;
    logic [3:0] memDst;
    logic       memRw;
    logic       brTaken;
    logic       rst;
  } vec_t;

  // Expected output patterns: {pc_we, ifid_we, ifid_flush, idex_bubble, halted}
  localparam logic [4:0] NORMAL    = 5'b11000;
  localparam logic [4:0] STALL     = 5'b00010;
  localparam logic [4:0] FLUSH     = 5'b11100;
  localparam logic [4:0] HALTPASS  = 5'b00000;
  localparam logic [4:0] DRAINING  = 5'b00010;
  localparam logic [4:0] HALTEDOUT = 5'b00011;
  localparam logic [4:0] RSTHALTED = 5'b11001;

  vec_t       nv;
  logic [4:0] expQ[$];
  string      nameQ[$];
  int         stallQ[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clock = ~clock;

  hazard_ctrl dut (
    .clk          (clock),
    .rst          (reset),
    .id_valid     (idValid),
    .id_src1      (idSrc1),
    .id_src2      (idSrc2),
    .id_use1      (idUse1),
    .id_use2      (idUse2),
    .id_br_reg    (idBrReg),
    .id_halt      (idHalt),
    .ex_dst       (exDst),
    .ex_regwrite  (exRegwrite),
    .ex_memread   (exMemread),
    .mem_dst      (memDst),
    .mem_regwrite (memRegwrite),
    .branch_taken (branchTaken),
    .pc_we        (pcWe),
    .ifid_we      (ifidWe),
    .ifid_flush   (ifidFlush),
    .idex_bubble  (idexBubble),
    .halted       (halted)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cnt    (stallCnt)
`endif
  );

  task automatic driveVec(input vec_t v);
    idValid     = v.valid;
    idSrc1      = v.src1;
    idSrc2      = v.src2;
    idUse1      = v.use1;
    idUse2      = v.use2;
    idBrReg     = v.brReg;
    idHalt      = v.halt;
    exDst       = v.exDst;
    exRegwrite  = v.exRw;
    exMemread   = v.exMr;
    memDst      = v.memDst;
    memRegwrite = v.memRw;
    branchTaken = v.brTaken;
    reset       = v.rst;
  endtask

  // Drive the pending vector just after a rising edge and queue what the DUT must show this cycle.
  task automatic applyStimulus(input string name, input logic [4:0] expOut, input int expStall);
    @(posedge clock);
    #1;
    driveVec(nv);
    expQ.push_back(expOut);
    nameQ.push_back(name);
    stallQ.push_back(expStall);
  endtask

  task automatic checkOutput();
    logic [4:0] expOut;
    logic [4:0] actOut;
    string      name;
    int         expStall;
    expOut   = expQ.pop_front();
    name     = nameQ.pop_front();
    expStall = stallQ.pop_front();
    actOut   = {pcWe, ifidWe, ifidFlush, idexBubble, halted};
    checks++;
    if (actOut !== expOut) begin
      errors++;
      $display("[TB] FAIL %s: outputs got %b expected %b", name, actOut, expOut);
    end
`ifdef HAZ_PERF_CNT_EN
    checks++;
    if (stallCnt !== 16'(expStall)) begin
      errors++;
      $display("[TB] FAIL %s stall_cnt: got %0d expected %0d", name, stallCnt, expStall);
    end
`endif
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (expQ.size() != 0) checkOutput();
    end
  end

  initial begin
    nv = '0;
    nv.rst = 1'b1;
    driveVec(nv);

    applyStimulus("reset0", NORMAL, 0);
    applyStimulus("reset1", NORMAL, 0);
    nv = '0;
    applyStimulus("idle", NORMAL, 0);

    // Load to R3 in EX, decode uses src2=R3
    nv = '0; nv.valid = 1; nv.src2 = 4'd3; nv.use2 = 1; nv.exDst = 4'd3; nv.exRw = 1; nv.exMr = 1;
    applyStimulus("loaduse_src2", STALL, 0);
    nv.exDst = 4'd0; nv.exRw = 0; nv.exMr = 0; nv.memDst = 4'd3; nv.memRw = 1;
    applyStimulus("loaduse_resume", NORMAL, 1);

    // Register branch on R5 behind a load of R5
    nv = '0; nv.valid = 1; nv.brReg = 1; nv.src1 = 4'd5; nv.use1 = 1; nv.exDst = 4'd5; nv.exRw = 1; nv.exMr = 1;
    applyStimulus("br_ex_match", STALL, 1);
    nv.exDst = 4'd0; nv.exRw = 0; nv.exMr = 0; nv.memDst = 4'd5; nv.memRw = 1;
    applyStimulus("br_mem_match", STALL, 2);
    nv.memDst = 4'd0; nv.memRw = 0;
    applyStimulus("br_resume", NORMAL, 3);

    // R0 never hazards
    nv = '0; nv.valid = 1; nv.src1 = 4'd0; nv.use1 = 1; nv.brReg = 1; nv.exDst = 4'd0; nv.exRw = 1; nv.exMr = 1; nv.memRw = 1;
    applyStimulus("r0_no_stall", NORMAL, 3);
    nv = '0; nv.src1 = 4'd4; nv.use1 = 1; nv.exDst = 4'd4; nv.exRw = 1; nv.exMr = 1;
    applyStimulus("invalid_no_stall", NORMAL, 3);

    nv = '0; nv.valid = 1; nv.brTaken = 1;
    applyStimulus("branch_flush", FLUSH, 3);
    nv = '0; nv.valid = 1; nv.brTaken = 1; nv.src1 = 4'd7; nv.use1 = 1; nv.exDst = 4'd7; nv.exRw = 1; nv.exMr = 1;
    applyStimulus("branch_vs_hazard", STALL, 3);
    nv = '0; nv.valid = 1; nv.src1 = 4'd7; nv.use1 = 0; nv.src2 = 4'd2; nv.use2 = 1; nv.exDst = 4'd7; nv.exRw = 1; nv.exMr = 1;
    applyStimulus("unused_src_match", NORMAL, 4);
    nv = '0; nv.valid = 1; nv.src1 = 4'd6; nv.use1 = 1; nv.exDst = 4'd6; nv.exRw = 1; nv.exMr = 0;
    applyStimulus("alu_no_stall", NORMAL, 4);

    // Halt held back by a hazard, then passes with priority over a taken branch
    nv = '0; nv.valid = 1; nv.halt = 1; nv.brTaken = 1; nv.src1 = 4'd9; nv.use1 = 1; nv.exDst = 4'd9; nv.exRw = 1; nv.exMr = 1;
    applyStimulus("halt_hazard", STALL, 4);
    nv.exDst = 4'd0; nv.exRw = 0; nv.exMr = 0;
    applyStimulus("halt_pass", HALTPASS, 5);
    nv = '0; nv.valid = 1; nv.brTaken = 1;
    applyStimulus("drain1", DRAINING, 5);
    applyStimulus("drain2", DRAINING, 5);
    applyStimulus("drain3", DRAINING, 5);
    nv = '0; nv.valid = 1; nv.halt = 1; nv.brTaken = 1;
    applyStimulus("halted_ignore", HALTEDOUT, 5);
    nv = '0; nv.valid = 1; nv.src1 = 4'd2; nv.use1 = 1; nv.exDst = 4'd2; nv.exRw = 1; nv.exMr = 1;
    applyStimulus("halted_no_count", HALTEDOUT, 5);
    nv = '0; nv.rst = 1;
    applyStimulus("halted_rst", RSTHALTED, 5);
    nv = '0;
    applyStimulus("after_rst", NORMAL, 0);

    // Reset in the middle of a drain
    nv = '0; nv.valid = 1; nv.halt = 1;
    applyStimulus("halt2_pass", HALTPASS, 0);
    nv = '0;
    applyStimulus("drain2_1", DRAINING, 0);
    nv.rst = 1;
    applyStimulus("drain2_rst", NORMAL, 0);
    nv = '0;
    applyStimulus("drain_rst_run", NORMAL, 0);
    applyStimulus("drain_rst_run2", NORMAL, 0);

    // Reset in the middle of a stall
    nv = '0; nv.valid = 1; nv.src1 = 4'd8; nv.use1 = 1; nv.exDst = 4'd8; nv.exRw = 1; nv.exMr = 1;
    applyStimulus("stall_pre_rst", STALL, 0);
    nv.rst = 1;
    applyStimulus("stall_rst", STALL, 1);
    nv = '0;
    applyStimulus("stall_rst_after", NORMAL, 0);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clock);
    #1;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_queue: got %0d pending expected 0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
